// File: rtl/sum_accumulator.sv
// Multi-operand accumulator: sums p_count unsigned operands from a valid/ready
// stream and offers the total on a second valid/ready handshake.
module sum_accumulator #(
    parameter  int unsigned p_width     = 6,
    parameter  int unsigned p_count     = 4,
    localparam int unsigned p_idx_width = $clog2(p_count),
    localparam int unsigned p_sum_width = p_width + p_idx_width
) (
    input  logic                   i_w_clk,
    input  logic                   i_w_reset,
    input  logic                   i_w_clear,
    input  logic                   i_w_valid,
    output logic                   o_w_ready,
    input  logic [p_width-1:0]     i_w_data,
    output logic                   o_w_valid,
    input  logic                   i_w_ready,
    output logic [p_sum_width-1:0] o_w_sum,
    output logic [p_idx_width-1:0] o_w_index
);

    localparam logic [p_idx_width-1:0] idx_last = p_idx_width'(p_count - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [p_sum_width-1:0] acc_q, acc_d;
    logic [p_idx_width-1:0] idx_q, idx_d;

    // State, accumulator and operand index registers
    always_ff @(posedge i_w_clk or posedge i_w_reset) begin
        if (i_w_reset) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state: clear overrides everything, including a pending transfer
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        if (i_w_clear) begin
            state_d = ACCUM;
            acc_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (i_w_valid) begin
                        acc_d = acc_q + p_sum_width'(i_w_data);
                        if (idx_q == idx_last) begin
                            idx_d   = '0;
                            state_d = DONE;
                        end else begin
                            idx_d = idx_q + p_idx_width'(1);
                        end
                    end
                end
                DONE: begin
                    if (i_w_ready) begin
                        acc_d   = '0;
                        state_d = ACCUM;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    // Handshake flags are decoded straight from the state flop
    assign o_w_ready = (state_q == ACCUM);
    assign o_w_valid = (state_q == DONE);
    assign o_w_sum   = acc_q;
    assign o_w_index = idx_q;

endmodule

// File: doc/sum_accumulator.md
Name: sum_accumulator

Overview:
- Multi-operand accumulator that sits directly downstream of the parameterized adder.
- Consumes a stream of unsigned p_width-bit operands over a valid/ready handshake and sums exactly p_count of them.
- Presents the total on a second valid/ready handshake and holds it until the next stage takes it.
- The result width is sized so the sum can never overflow.

Parameters:
- p_width, 6, operand width in bits (>=1).
- p_count, 4, operands per result (>=2).
- p_sum_width, p_width+$clog2(p_count), result width. Derived, not overridden. Guarantees p_count*(2^p_width-1) fits.

Ports:
- i_w_clk  input  1  clock; all state updates on rising edge.
- i_w_reset  input  1  asynchronous, active-high reset.
- i_w_clear  input  1  synchronous abort; discards partial or held sum.
- i_w_valid  input  1  upstream operand valid.
- o_w_ready  output  1  block can accept an operand this cycle.
- i_w_data  input  p_width  operand, unsigned.
- o_w_valid  output  1  result valid.
- i_w_ready  input  1  downstream accepts result this cycle.
- o_w_sum  output  p_sum_width  accumulated result, unsigned.
- o_w_index  output  $clog2(p_count)  number of operands accepted so far in the current group (0..p_count-1).

Behaviour:
- Two states: ACCUM and DONE. All outputs are registered or decoded from state.
- Reset (async, any time including mid-group or in DONE):
  - state=ACCUM; accumulator=0; index=0.
  - o_w_valid=0, o_w_ready=1, o_w_sum=0, o_w_index=0.
- ACCUM:
  - o_w_ready=1, o_w_valid=0.
  - An operand is accepted when i_w_valid & o_w_ready at a rising edge. On acceptance: acc <= acc + zero-extended i_w_data; index <= index+1.
  - Acceptance of the p_count-th operand (index==p_count-1): final acc is registered, index wraps to 0, state -> DONE.
  - i_w_valid low: no change. Gaps of any length are allowed.
- DONE:
  - o_w_valid=1, o_w_ready=0.
  - o_w_sum holds the total, stable until transfer.
  - On i_w_valid & o_w_ready... not possible here; upstream data is ignored.
  - When o_w_valid & i_w_ready at an edge: acc <= 0, state -> ACCUM.
  - i_w_ready low: hold indefinitely, no loss.
- Latency: o_w_valid rises the cycle after the last operand edge.
- Minimum period per result: p_count+1 cycles (p_count accepts + 1 DONE cycle with i_w_ready=1).
- o_w_sum in ACCUM shows the running partial sum (informational only; meaningful only when o_w_valid=1).
- i_w_clear:
  - Highest priority after reset. acc<=0, index<=0, state<=ACCUM; any same-cycle operand is not accepted.
  - In DONE, the held result is dropped, even if i_w_ready=1 that cycle. Downstream must treat a clear edge as no transfer.
- Arithmetic: unsigned, zero-extension only; no saturation needed by construction.
- X on i_w_data is irrelevant when i_w_valid=0.

Test Plan (p_width=6, p_count=4):
- Reset, then back-to-back operands 1,2,3,4 with i_w_valid=1 and i_w_ready=1 -> o_w_valid high exactly 1 cycle after the 4th accept, o_w_sum=10; o_w_ready=0 that cycle, 1 the next.
- Operands 63,63,63,63 -> o_w_sum=252 (8'hFC), no overflow; o_w_index sequence 0,1,2,3,0.
- Result 5+5+5+5=20 with i_w_ready held low 7 cycles -> o_w_valid and o_w_sum=20 stable 7 cycles, o_w_ready=0 throughout, upstream operands ignored; transfer on first i_w_ready=1, next group sums from 0.
- Operands 10,20 then i_w_valid low 3 cycles, then 30,40 -> o_w_sum=100; index holds 2 during the gap.
- Operands 7,8,9, then i_w_clear together with valid operand 50 -> index=0, partial discarded, 50 not accepted; then 1,1,1,1 -> o_w_sum=4.
- Assert i_w_reset asynchronously mid-cycle while in DONE with sum 252 -> o_w_valid, o_w_sum and o_w_index drop to 0 immediately, without waiting for a clock edge; o_w_ready=1; after release, 2,2,2,2 -> o_w_sum=8.
